// File: rtl/vga_sync_gen.sv
// VGA timing master: pixel-rate tick, horizontal/vertical counters, sync pulses,
// active-video flag and a frame-start pulse. All outputs come from registers so
// downstream logic sees mutually consistent, glitch-free values.
// Optional feature: define VGA_FRAME_CNT_EN to add an 8-bit frame counter output.
module vga_sync_gen #(
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned H_DISPLAY = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_DISPLAY = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic       p_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [7:0] frame_cnt
`endif
);

   localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_DISP   = 10'(H_DISPLAY);
   localparam logic [9:0] V_DISP   = 10'(V_DISPLAY);
   localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [9:0]       x_q, x_d;
   logic [9:0]       y_q, y_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             video_on_q, video_on_d;
   logic             frame_start_q, frame_start_d;
   logic             tick;
`ifdef VGA_FRAME_CNT_EN
   logic [7:0]       frame_cnt_q, frame_cnt_d;
`endif

   assign tick = (div_q == DIV_MAX);

   // Clock divider: counts 0..CLK_DIV-1 and wraps.
   always_comb begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
   end

   // Next counts and the flags decoded from them, so flags line up with the counts they follow.
   always_comb begin
      x_d           = x_q;
      y_d           = y_q;
      frame_start_d = 1'b0;
      if (tick) begin
         if (x_q == H_MAX) begin
            x_d = '0;
            if (y_q == V_MAX) begin
               y_d           = '0;
               frame_start_d = 1'b1;
            end else begin
               y_d = y_q + 10'd1;
            end
         end else begin
            x_d = x_q + 10'd1;
         end
      end
      hsync_d    = !((x_d >= HS_START) && (x_d <= HS_END));
      vsync_d    = !((y_d >= VS_START) && (y_d <= VS_END));
      video_on_d = (x_d < H_DISP) && (y_d < V_DISP);
   end

`ifdef VGA_FRAME_CNT_EN
   // Frame counter steps in the same clock that frame_start rises; wraps naturally at 8 bits.
   always_comb begin
      frame_cnt_d = frame_start_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
   end
`endif

   // State registers; reset values describe pixel (0,0) of an idle frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q         <= '0;
         x_q           <= '0;
         y_q           <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         video_on_q    <= 1'b1;
         frame_start_q <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
         frame_cnt_q   <= '0;
`endif
      end else begin
         div_q         <= div_d;
         x_q           <= x_d;
         y_q           <= y_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         frame_start_q <= frame_start_d;
`ifdef VGA_FRAME_CNT_EN
         frame_cnt_q   <= frame_cnt_d;
`endif
      end
   end

   // With CLK_DIV=1 the divider decode is constantly true, so mask the tick while in reset.
   assign p_tick      = reset_n & tick;
   assign pixel_x     = x_q;
   assign pixel_y     = y_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign frame_start = frame_start_q;
`ifdef VGA_FRAME_CNT_EN
   assign frame_cnt   = frame_cnt_q;
`endif

endmodule
